// File: rtl/mul_operand_streamer_pkg.sv
// Shared defaults and FSM state encoding for the multiplier operand streamer.
package mul_operand_streamer_pkg;

    localparam int MUL_DW    = 32;
    localparam int MUL_DEPTH = 32;
    localparam int MUL_AW    = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/mul_operand_streamer_if.sv
// Multiplier input port: operand pair {a, b} with strobe/acknowledge handshake.
interface mul_operand_streamer_if
    import mul_operand_streamer_pkg::*;
#(
    parameter int DW = MUL_DW
) ();

    logic [2*DW-1:0] output_mul;
    logic            output_mul_stb;
    logic            output_mul_ack;

    modport master (
        output output_mul,
        output output_mul_stb,
        input  output_mul_ack
    );

    modport slave (
        input  output_mul,
        input  output_mul_stb,
        output output_mul_ack
    );

endinterface

// File: rtl/mul_operand_streamer_operand_ram.sv
// Operand-pair table: one synchronous write port, one registered read port.
module operand_ram #(
    parameter int W     = 64,
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // The read register doubles as the presented pair, so it alone is reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/mul_operand_streamer.sv
// Plays a preloaded table of operand pairs into the multiplier input port,
// one pair per stb/ack transfer, optionally looping until stopped.
module mul_operand_streamer
    import mul_operand_streamer_pkg::*;
#(
    parameter int DW    = MUL_DW,
    parameter int DEPTH = MUL_DEPTH,
    parameter int AW    = MUL_AW
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_en,
    input  logic [AW-1:0]         load_addr,
    input  logic [2*DW-1:0]       load_data,
    input  logic                  start,
    input  logic                  stop,
    input  logic [AW:0]           count,
    input  logic                  loop_en,
    mul_operand_streamer_if.master mul_if,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           sent_cnt
);

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_t        state_q, state_d;
    logic [AW-1:0] rd_addr_q, rd_addr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          loop_q, loop_d;
    logic          stop_q, stop_d;
    logic [15:0]   sent_q, sent_d;

    logic          ram_we;
    logic          ram_re;
    logic [AW-1:0] ram_raddr;
    logic [AW:0]   count_clamped;
    logic          xfer;
    logic          last;
    logic [AW-1:0] next_idx;

    assign count_clamped = (count > DEPTH_C) ? DEPTH_C : count;
    assign xfer          = mul_if.output_mul_stb && mul_if.output_mul_ack;
    assign last          = ({1'b0, rd_addr_q} == (cnt_q - (AW+1)'(1)));
    assign next_idx      = last ? '0 : rd_addr_q + AW'(1);

    // Table writes only land while idle so a run always sees a stable table.
    assign ram_we = load_en && ((state_q == IDLE) || (state_q == DONE));

    always_comb begin
        state_d   = state_q;
        rd_addr_d = rd_addr_q;
        cnt_d     = cnt_q;
        loop_d    = loop_q;
        stop_d    = stop_q;
        sent_d    = sent_q;
        ram_re    = 1'b0;
        ram_raddr = rd_addr_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    cnt_d     = count_clamped;
                    loop_d    = loop_en;
                    rd_addr_d = '0;
                    sent_d    = '0;
                    stop_d    = 1'b0;
                    state_d   = (count_clamped == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                ram_re    = 1'b1;
                ram_raddr = '0;
                state_d   = SEND;
                if (stop) stop_d = 1'b1;
            end
            SEND: begin
                if (xfer) begin
                    sent_d = sat_inc(sent_q);
                    if ((last && !loop_q) || stop || stop_q) begin
                        state_d = DONE;
                    end else begin
                        // Prefetch the next entry on the transfer edge to keep stb high.
                        rd_addr_d = next_idx;
                        ram_re    = 1'b1;
                        ram_raddr = next_idx;
                    end
                end else if (stop) begin
                    stop_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            rd_addr_q <= '0;
            cnt_q     <= '0;
            loop_q    <= 1'b0;
            stop_q    <= 1'b0;
            sent_q    <= '0;
        end else begin
            state_q   <= state_d;
            rd_addr_q <= rd_addr_d;
            cnt_q     <= cnt_d;
            loop_q    <= loop_d;
            stop_q    <= stop_d;
            sent_q    <= sent_d;
        end
    end

    operand_ram #(
        .W     (2*DW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (ram_we),
        .waddr (load_addr),
        .wdata (load_data),
        .re    (ram_re),
        .raddr (ram_raddr),
        .rdata (mul_if.output_mul)
    );

    assign mul_if.output_mul_stb = (state_q == SEND);
    assign busy                  = (state_q == FETCH) || (state_q == SEND);
    assign done                  = (state_q == DONE);
    assign sent_cnt              = sent_q;

endmodule

// File: tb/tb_mul_operand_streamer.sv
// Directed bench for mul_operand_streamer: playback, backpressure, clamp, loop/stop, reset.
module tb_mul_operand_streamer;

    localparam logic [63:0] BASE = 64'h3F80_0000_4000_0000;
    localparam logic [63:0] ALT0 = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] JUNK = 64'hDEAD_BEEF_DEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        load_en = 1'b0;
    logic [4:0]  load_addr = '0;
    logic [63:0] load_data = '0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [5:0]  count = '0;
    logic        loop_en = 1'b0;
    logic        busy;
    logic        done;
    logic [15:0] sent_cnt;

    int total = 0;
    int bad   = 0;

    mul_operand_streamer_if #(.DW(32)) mul_if ();

    mul_operand_streamer #(.DW(32), .DEPTH(32), .AW(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data),
        .start     (start),
        .stop      (stop),
        .count     (count),
        .loop_en   (loop_en),
        .mul_if    (mul_if.master),
        .busy      (busy),
        .done      (done),
        .sent_cnt  (sent_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic load(input int addr, input logic [63:0] data);
        load_en   = 1'b1;
        load_addr = 5'(addr);
        load_data = data;
        step();
        load_en   = 1'b0;
    endtask

    task automatic start_run(input logic [5:0] c, input logic lp);
        count   = c;
        loop_en = lp;
        start   = 1'b1;
        step();
        start   = 1'b0;
    endtask

    initial begin
        mul_if.output_mul_ack = 1'b0;
        step();
        step();
        chk("rst_stb",  64'(mul_if.output_mul_stb), 64'd0);
        chk("rst_out",  mul_if.output_mul, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_sent", 64'(sent_cnt), 64'd0);
        rst = 1'b1;
        step();

        for (int i = 0; i < 32; i++) load(i, BASE + 64'(i));

        // Basic run, ack tied high.
        mul_if.output_mul_ack = 1'b1;
        start_run(6'd4, 1'b0);
        chk("basic_fetch_busy", 64'(busy), 64'd1);
        chk("basic_fetch_stb",  64'(mul_if.output_mul_stb), 64'd0);
        step();
        for (int i = 0; i < 4; i++) begin
            chk("basic_stb", 64'(mul_if.output_mul_stb), 64'd1);
            chk("basic_out", mul_if.output_mul, BASE + 64'(i));
            step();
        end
        chk("basic_stb_end", 64'(mul_if.output_mul_stb), 64'd0);
        chk("basic_done",    64'(done), 64'd1);
        chk("basic_sent",    64'(sent_cnt), 64'd4);

        // Backpressure: ack 1,0,0,1,0,1,1 carries entries 0,1,1,1,2,2,3.
        begin
            logic [6:0]  ack_pat;
            logic [63:0] exp_idx [7];
            ack_pat = 7'b1101001;
            exp_idx = '{0, 1, 1, 1, 2, 2, 3};
            start_run(6'd4, 1'b0);
            step();
            for (int k = 0; k < 7; k++) begin
                mul_if.output_mul_ack = ack_pat[k];
                chk("bp_stb", 64'(mul_if.output_mul_stb), 64'd1);
                chk("bp_out", mul_if.output_mul, BASE + exp_idx[k]);
                step();
            end
        end
        mul_if.output_mul_ack = 1'b1;
        chk("bp_stb_end", 64'(mul_if.output_mul_stb), 64'd0);
        chk("bp_done",    64'(done), 64'd1);
        chk("bp_sent",    64'(sent_cnt), 64'd4);

        // count=0: straight to DONE, nothing presented.
        start_run(6'd0, 1'b0);
        chk("c0_done", 64'(done), 64'd1);
        chk("c0_busy", 64'(busy), 64'd0);
        chk("c0_stb",  64'(mul_if.output_mul_stb), 64'd0);
        chk("c0_sent", 64'(sent_cnt), 64'd0);
        step();
        chk("c0_stb_later", 64'(mul_if.output_mul_stb), 64'd0);

        // count=40 clamps to the 32-entry table.
        start_run(6'd40, 1'b0);
        step();
        for (int i = 0; i < 32; i++) begin
            chk("c40_stb", 64'(mul_if.output_mul_stb), 64'd1);
            chk("c40_out", mul_if.output_mul, BASE + 64'(i));
            step();
        end
        chk("c40_stb_end", 64'(mul_if.output_mul_stb), 64'd0);
        chk("c40_done",    64'(done), 64'd1);
        chk("c40_sent",    64'(sent_cnt), 64'd32);

        // Looping run of 3, stop sampled with the 7th transfer.
        start_run(6'd3, 1'b1);
        step();
        for (int i = 0; i < 7; i++) begin
            chk("loop_out", mul_if.output_mul, BASE + 64'(i % 3));
            if (i == 6) stop = 1'b1;
            step();
        end
        stop = 1'b0;
        chk("loop_stb_end", 64'(mul_if.output_mul_stb), 64'd0);
        chk("loop_done",    64'(done), 64'd1);
        chk("loop_sent",    64'(sent_cnt), 64'd7);

        // Writes during a run are dropped.
        start_run(6'd4, 1'b0);
        step();
        chk("busyld_out0", mul_if.output_mul, BASE);
        load_en   = 1'b1;
        load_addr = 5'd1;
        load_data = JUNK;
        step();
        load_en   = 1'b0;
        chk("busyld_out1", mul_if.output_mul, BASE + 64'd1);
        step();
        step();
        step();
        chk("busyld_done", 64'(done), 64'd1);
        start_run(6'd4, 1'b0);
        step();
        step();
        chk("busyld_next_out1", mul_if.output_mul, BASE + 64'd1);
        step();
        step();
        step();
        chk("busyld_next_done", 64'(done), 64'd1);

        // Entry-0 write together with start is seen by FETCH.
        load_en   = 1'b1;
        load_addr = 5'd0;
        load_data = ALT0;
        start_run(6'd1, 1'b0);
        load_en   = 1'b0;
        step();
        chk("ldstart_out", mul_if.output_mul, ALT0);
        step();
        chk("ldstart_done", 64'(done), 64'd1);
        chk("ldstart_sent", 64'(sent_cnt), 64'd1);
        load(0, BASE);

        // Reset mid-stream with a pending pair.
        mul_if.output_mul_ack = 1'b0;
        start_run(6'd4, 1'b0);
        step();
        mul_if.output_mul_ack = 1'b1;
        step();
        mul_if.output_mul_ack = 1'b0;
        step();
        chk("mid_stb",  64'(mul_if.output_mul_stb), 64'd1);
        chk("mid_out",  mul_if.output_mul, BASE + 64'd1);
        chk("mid_sent", 64'(sent_cnt), 64'd1);
        rst = 1'b0;
        #1;
        chk("mrst_stb",  64'(mul_if.output_mul_stb), 64'd0);
        chk("mrst_busy", 64'(busy), 64'd0);
        chk("mrst_done", 64'(done), 64'd0);
        chk("mrst_sent", 64'(sent_cnt), 64'd0);
        chk("mrst_out",  mul_if.output_mul, 64'd0);
        #2;
        rst = 1'b1;
        step();
        mul_if.output_mul_ack = 1'b1;
        start_run(6'd4, 1'b0);
        step();
        for (int i = 0; i < 4; i++) begin
            chk("replay_out", mul_if.output_mul, BASE + 64'(i));
            step();
        end
        chk("replay_done", 64'(done), 64'd1);
        chk("replay_sent", 64'(sent_cnt), 64'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
